// File: rtl/axi_stream_wr_master_pkg.sv
// Shared AXI encodings and FSM state type for the stream-to-AXI write master.
package axi_stream_wr_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    localparam logic [3:0] AWCACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] AWPROT_DEFAULT  = 3'b000;

endpackage

// File: rtl/axi_stream_wr_master_burst_len_calc.sv
// Beats for the next burst: min(remaining, MAX_BURST_LEN[, words left before the 4 KB line]).
// Macro AXI_WR_MASTER_4K_SPLIT_EN adds the 4 KB boundary cap.
module axi_burst_len_calc #(
    parameter int ADDR_WIDTH    = 16,
    parameter int LEN_WIDTH     = 16,
    parameter int STRB_WIDTH    = 4,
    parameter int MAX_BURST_LEN = 256
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  remaining,
    output logic [LEN_WIDTH-1:0]  beats
);

    localparam int SIZE = $clog2(STRB_WIDTH);

`ifdef AXI_WR_MASTER_4K_SPLIT_EN
    logic [12:0]          bytes_to_4k;
    logic [LEN_WIDTH-1:0] words_to_4k;

    assign bytes_to_4k = 13'h1000 - {1'b0, addr[11:0]};
    assign words_to_4k = LEN_WIDTH'(bytes_to_4k >> SIZE);

    always_comb begin
        beats = remaining;
        if (beats > LEN_WIDTH'(MAX_BURST_LEN))
            beats = LEN_WIDTH'(MAX_BURST_LEN);
        if (beats > words_to_4k)
            beats = words_to_4k;
    end
`else
    logic unused_addr;
    assign unused_addr = ^addr;

    always_comb begin
        beats = remaining;
        if (beats > LEN_WIDTH'(MAX_BURST_LEN))
            beats = LEN_WIDTH'(MAX_BURST_LEN);
    end
`endif

endmodule

// File: rtl/axi_stream_wr_master.sv
// Writes a valid/ready word stream to memory as AXI4 INCR bursts, one burst outstanding at a time.
// Optional 4 KB burst splitting via AXI_WR_MASTER_4K_SPLIT_EN (see axi_burst_len_calc).
//
// state | meaning
// IDLE  | waiting for a command; len==0 completes here without AXI traffic
// ADDR  | awvalid held with the burst address/length until awready
// DATA  | stream passed straight through to W; wlast on the final beat
// RESP  | bready high; on B either issue the next burst or finish the command
module axi_stream_wr_master
    import axi_stream_wr_master_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = 8,
    parameter int AWID          = 0,
    parameter int LEN_WIDTH     = 16,
    parameter int MAX_BURST_LEN = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  s_cmd_len,
    input  logic                  s_cmd_valid,
    output logic                  s_cmd_ready,
    input  logic [DATA_WIDTH-1:0] s_data_tdata,
    input  logic                  s_data_tvalid,
    output logic                  s_data_tready,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int SIZE = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [LEN_WIDTH-1:0]  beats;
    logic [7:0]            beat_cnt;
    logic                  err_sticky;
    logic                  done_q;
    logic                  error_q;
    logic                  busy_q;
    logic                  rdy_en;

    logic cmd_hs, w_hs, b_err, last_burst;
    logic unused_bid;

    assign unused_bid = ^m_axi_bid;

    assign cmd_hs     = s_cmd_valid && s_cmd_ready;
    assign w_hs       = m_axi_wvalid && m_axi_wready;
    assign b_err      = (m_axi_bresp != RESP_OKAY);
    assign last_burst = (remaining_q == beats);

    axi_burst_len_calc #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .LEN_WIDTH     (LEN_WIDTH),
        .STRB_WIDTH    (STRB_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_len_calc (
        .addr      (addr_q),
        .remaining (remaining_q),
        .beats     (beats)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cmd_hs && s_cmd_len != '0) state_nxt = ADDR;
            ADDR: if (m_axi_awready) state_nxt = DATA;
            DATA: if (w_hs && beat_cnt == 8'd0) state_nxt = RESP;
            RESP: if (m_axi_bvalid) state_nxt = last_burst ? IDLE : ADDR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_cmd_ready   = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        s_data_tready = 1'b0;
        m_axi_bready  = 1'b0;
        case (state)
            // ready is withheld on the done cycle and until the first clock after reset
            IDLE: s_cmd_ready = rdy_en && !done_q;
            ADDR: m_axi_awvalid = 1'b1;
            DATA: begin
                m_axi_wvalid  = s_data_tvalid;
                s_data_tready = m_axi_wready;
                m_axi_wlast   = (beat_cnt == 8'd0);
            end
            RESP: m_axi_bready = 1'b1;
            default: ;
        endcase
    end

    assign m_axi_awid    = ID_WIDTH'(AWID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(beats - LEN_WIDTH'(1));
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AWCACHE_DEFAULT;
    assign m_axi_awprot  = AWPROT_DEFAULT;
    assign m_axi_wdata   = s_data_tdata;
    assign m_axi_wstrb   = '1;

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            beat_cnt    <= '0;
            err_sticky  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            rdy_en      <= 1'b0;
        end else begin
            rdy_en  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state)
                IDLE: if (cmd_hs) begin
                    addr_q      <= s_cmd_addr & ~ALIGN_MASK;
                    remaining_q <= s_cmd_len;
                    err_sticky  <= 1'b0;
                    if (s_cmd_len == '0)
                        done_q <= 1'b1;
                    else
                        busy_q <= 1'b1;
                end
                ADDR: if (m_axi_awready)
                    beat_cnt <= 8'(beats - LEN_WIDTH'(1));
                DATA: if (w_hs)
                    beat_cnt <= beat_cnt - 8'd1;
                RESP: if (m_axi_bvalid) begin
                    err_sticky  <= err_sticky | b_err;
                    remaining_q <= remaining_q - beats;
                    addr_q      <= addr_q + (ADDR_WIDTH'(beats) << SIZE);
                    if (last_burst) begin
                        done_q  <= 1'b1;
                        error_q <= err_sticky | b_err;
                        busy_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_stream_wr_master.sv
// Scoreboard bench: random stream/slave stalls, burst-level reference model, RAM shadow compare.
module tb_axi_stream_wr_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_cmd_addr;
    logic [15:0] s_cmd_len;
    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic [31:0] s_data_tdata;
    logic        s_data_tvalid;
    logic        s_data_tready;
    logic [7:0]  awid;
    logic [15:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    axi_stream_wr_master #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8),
        .AWID(0), .LEN_WIDTH(16), .MAX_BURST_LEN(256)
    ) dut (
        .clk(clk), .rst(rst),
        .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_data_tdata(s_data_tdata), .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
        .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .busy(busy), .done(done), .error(error)
    );

    typedef struct { logic [15:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [31:0] data; logic last; } w_t;

    aw_t         exp_aw[$];
    w_t          exp_w[$];
    bit          exp_done[$];
    logic [31:0] src_q[$];
    logic [1:0]  bresp_q[$];
    logic [31:0] mem[16384];
    logic [31:0] exp_mem[16384];
    bit          stall_en = 1'b0;
    int          outstanding = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=missing expected=present", name);
    endtask

    // stream source: presents the head of src_q with random gaps when stalls are on
    initial begin : source
        bit hs;
        s_data_tvalid = 1'b0;
        s_data_tdata  = '0;
        forever begin
            @(negedge clk);
            hs = !rst && s_data_tvalid && s_data_tready;
            @(posedge clk); #1;
            if (hs && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
                s_data_tvalid = 1'b1;
                s_data_tdata  = src_q[0];
            end else begin
                s_data_tvalid = 1'b0;
            end
        end
    end

    // memory slave: RAM writes, random AW/W stalls, B after random delay with planned bresp
    initial begin : slave
        logic [13:0] w_idx;
        bit          b_pend, b_hs, r;
        int          b_wait;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 8'h00;
        w_idx = '0; b_pend = 1'b0; b_wait = 0;
        forever begin
            @(negedge clk);
            r = rst;
            b_hs = 1'b0;
            if (r) begin
                w_idx  = '0;
                b_pend = 1'b0;
            end else begin
                if (awvalid && awready) w_idx = awaddr[15:2];
                if (wvalid && wready) begin
                    mem[w_idx] = wdata;
                    w_idx = w_idx + 14'd1;
                    if (wlast) begin
                        b_pend = 1'b1;
                        b_wait = $urandom_range(0, 3);
                    end
                end
                b_hs = bvalid && bready;
            end
            @(posedge clk); #1;
            awready = !stall_en || ($urandom_range(0, 2) != 0);
            wready  = !stall_en || ($urandom_range(0, 2) != 0);
            if (r || b_hs) bvalid = 1'b0;
            if (!r && !bvalid && b_pend) begin
                if (b_wait == 0) begin
                    bvalid = 1'b1;
                    bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
                    b_pend = 1'b0;
                end else begin
                    b_wait--;
                end
            end
        end
    end

    // monitor: pops expectations whenever the DUT presents a handshake or done
    initial begin : monitor
        aw_t a;
        w_t  w;
        forever begin
            @(negedge clk);
            if (rst) begin
                outstanding = 0;
            end else begin
                if (awvalid && awready) begin
                    chk("aw_while_b_pending", outstanding, 0);
                    if (exp_aw.size() == 0) fail_now("aw_unexpected");
                    else begin
                        a = exp_aw.pop_front();
                        chk("awaddr", awaddr, a.addr);
                        chk("awlen", awlen, a.len);
                        chk("aw_const", {awid, awsize, awburst, awlock, awcache, awprot},
                            {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
                    end
                    outstanding++;
                end
                if (wvalid && wready) begin
                    if (exp_w.size() == 0) fail_now("w_unexpected");
                    else begin
                        w = exp_w.pop_front();
                        chk("wdata_wstrb", {wstrb, wdata}, {4'hF, w.data});
                        chk("wlast", wlast, w.last);
                    end
                end
                if (bvalid && bready) outstanding--;
                if (done) begin
                    if (exp_done.size() == 0) fail_now("done_unexpected");
                    else chk("done_error", error, exp_done.pop_front());
                end
            end
        end
    end

    // err_mode: 0 all OKAY, 1 SLVERR on first burst only, 2 random SLVERR per burst
    task automatic send_cmd(input logic [15:0] addr, input int len, input int err_mode, input bit abort);
        logic [31:0] data[$];
        int          base_w, a, rem, b, k, cnt, mism, seen;
        bit          any_err, first, ok;
        logic [1:0]  r;
        base_w = int'(addr) >> 2;
        for (int i = 0; i < len; i++) begin
            data.push_back($urandom);
            exp_mem[(base_w + i) & 16'h3FFF] = data[i];
            src_q.push_back(data[i]);
        end
        a = int'(addr) & 16'hFFFC; rem = len; k = 0; any_err = 1'b0; first = 1'b1;
        while (rem > 0) begin
            b = (rem < 256) ? rem : 256;
`ifdef AXI_WR_MASTER_4K_SPLIT_EN
            if (b > (4096 - (a % 4096)) / 4) b = (4096 - (a % 4096)) / 4;
`endif
            exp_aw.push_back('{addr: 16'(a), len: 8'(b - 1)});
            for (int j = 0; j < b; j++) begin
                exp_w.push_back('{data: data[k], last: (j == b - 1)});
                k++;
            end
            r = 2'b00;
            if (err_mode == 1 && first) r = 2'b10;
            if (err_mode == 2 && $urandom_range(0, 2) == 0) r = 2'b10;
            bresp_q.push_back(r);
            any_err |= (r != 2'b00);
            first = 1'b0;
            a = (a + b * 4) % 65536;
            rem -= b;
        end
        exp_done.push_back(any_err);

        @(posedge clk); #1;
        s_cmd_addr = addr; s_cmd_len = 16'(len); s_cmd_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (s_cmd_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin fail_now("cmd_ready_timeout"); s_cmd_valid = 1'b0; return; end
        @(posedge clk); #1;
        s_cmd_valid = 1'b0;

        if (len == 0) begin
            @(negedge clk);
            chk("len0_done_next_cycle", done, 1);
            chk("len0_no_awvalid", awvalid, 0);
            chk("ready_low_on_done", s_cmd_ready, 0);
            return;
        end
        @(negedge clk);
        chk("busy_after_accept", busy, 1);

        if (abort) begin
            cnt = 0; seen = 0;
            while (seen < 3 && cnt < 3000) begin
                @(negedge clk); cnt++;
                if (wvalid && wready) seen++;
            end
            if (seen < 3) fail_now("abort_data_timeout");
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("rst_mid_data_outputs", {awvalid, wvalid, bready, s_data_tready, busy, done, s_cmd_ready}, 7'b0);
            @(posedge clk); #2;
            exp_aw.delete(); exp_w.delete(); exp_done.delete(); src_q.delete(); bresp_q.delete();
            rst = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("ready_after_rst_drop", s_cmd_ready, 1);
            return;
        end

        cnt = 0;
        while (!done && cnt < 20000) begin
            @(negedge clk); cnt++;
        end
        if (!done) begin fail_now("done_timeout"); return; end
        chk("ready_low_on_done", s_cmd_ready, 0);
        mism = 0;
        for (int i = 0; i < len; i++)
            if (mem[(base_w + i) & 16'h3FFF] !== exp_mem[(base_w + i) & 16'h3FFF]) mism++;
        chk("ram_word_mismatches", mism, 0);
        chk("aw_left_over", exp_aw.size(), 0);
        chk("w_left_over", exp_w.size(), 0);
    endtask

    initial begin : driver
        s_cmd_addr = '0; s_cmd_len = '0; s_cmd_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {s_cmd_ready, awvalid, wvalid, bready, busy, done, error}, 7'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", s_cmd_ready, 1);

        send_cmd(16'h0100, 4, 0, 1'b0);
        send_cmd(16'h0000, 300, 0, 1'b0);
        send_cmd(16'h0FF8, 4, 0, 1'b0);
        send_cmd(16'h2000, 300, 1, 1'b0);
        send_cmd(16'h3000, 10, 0, 1'b0);
        stall_en = 1'b1;
        send_cmd(16'($urandom), 37, 0, 1'b0);
        for (int i = 0; i < 4; i++)
            send_cmd(16'($urandom), $urandom_range(1, 600), 2, 1'b0);
        send_cmd(16'hFFF0, 20, 0, 1'b0);
        stall_en = 1'b0;
        send_cmd(16'h0500, 0, 0, 1'b0);
        stall_en = 1'b1;
        send_cmd(16'h4000, 50, 0, 1'b1);
        send_cmd(16'h0200, 20, 0, 1'b0);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
